// File: rtl/mem_stage_pkg.sv
// MEM stage shared types: SRAM controller states and default sizing.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SRAM_DQ_W   = 16;
    localparam int DEF_SRAM_ADDR_W = 18;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int DEF_BASE_ADDR   = 1024;
    localparam int DEF_DEST_W      = 5;

endpackage

// File: rtl/mem_stage_param_sram_ctrl.sv
// Multi-beat SRAM sequencer: FSM, beat/wait counters, address map, tri-state.
module sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SRAM_DQ_W   = DEF_SRAM_DQ_W,
    parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en_in,
    input  logic                   mem_w_en_in,
    input  logic [DATA_W-1:0]      addr_in,
    input  logic [DATA_W-1:0]      wdata_in,
    output logic                   mem_stall,
    output logic [DATA_W-1:0]      rdata,
    inout  wire  [SRAM_DQ_W-1:0]   sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n
);

    localparam int BEATS = DATA_W / SRAM_DQ_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SHIFT = $clog2(DATA_W / 8);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [2:0]    LAST_WAIT = 3'(WAIT_CYCLES);

    mem_state_e        state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [2:0]        wait_q, wait_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] asm_q, asm_d;

    logic              req, start, active, drive;
    logic              cur_wr, beat_end, last;
    logic [DATA_W-1:0] cur_addr, cur_data, word, lin;

    // The request cycle in IDLE already serves as the first SRAM cycle,
    // so the access runs straight from the live inputs until they are latched.
    assign req      = mem_r_en_in | mem_w_en_in;
    assign start    = (state_q == IDLE) && req;
    assign active   = rst && (start || (state_q == ACCESS));
    assign cur_wr   = start ? mem_w_en_in : wr_q;
    assign cur_addr = start ? addr_in : addr_q;
    assign cur_data = start ? wdata_in : wdata_q;
    assign beat_end = (wait_q == LAST_WAIT);
    assign last     = beat_end && (beat_q == LAST_BEAT);
    assign drive    = active && cur_wr;

    assign word      = (cur_addr - DATA_W'(BASE_ADDR)) >> SHIFT;
    assign lin       = word * DATA_W'(BEATS) + DATA_W'(beat_q);
    assign sram_addr = active ? SRAM_ADDR_W'(lin) : '0;
    assign sram_we_n = ~drive;
    assign sram_dq   = drive ? cur_data[int'(beat_q) * SRAM_DQ_W +: SRAM_DQ_W] : 'z;
    assign mem_stall = req && (state_q != DONE);
    assign rdata     = asm_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr_in;
                    wdata_d = wdata_in;
                    wr_d    = mem_w_en_in;
                    state_d = last ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (active) begin
            if (beat_end) begin
                wait_d = 3'd0;
                beat_d = last ? '0 : beat_q + BW'(1);
                if (!cur_wr) asm_d[int'(beat_q) * SRAM_DQ_W +: SRAM_DQ_W] = sram_dq;
            end else begin
                wait_d = wait_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wait_q  <= 3'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
        end
    end

endmodule

// File: rtl/mem_stage_param.sv
// MEM pipeline stage: SRAM access sequencer plus the MEM/WB pipeline registers.
module mem_stage_param
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SRAM_DQ_W   = DEF_SRAM_DQ_W,
    parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int DEST_W      = DEF_DEST_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pc_in,
    input  logic                   wb_en_in,
    input  logic                   mem_r_en_in,
    input  logic                   mem_w_en_in,
    input  logic [DATA_W-1:0]      alu_result_in,
    input  logic [DATA_W-1:0]      st_val_in,
    input  logic [DEST_W-1:0]      dest_in,
    output logic [31:0]            pc,
    output logic                   wb_en,
    output logic                   mem_r_en,
    output logic [DATA_W-1:0]      alu_result,
    output logic [DATA_W-1:0]      mem_read_value,
    output logic [DEST_W-1:0]      dest,
    output logic                   mem_stall,
    inout  wire  [SRAM_DQ_W-1:0]   sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n
);

    logic              stall, is_load;
    logic [DATA_W-1:0] rdata;

    logic [31:0]       pc_q, pc_d;
    logic              wb_en_q, wb_en_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mrv_q, mrv_d;
    logic [DEST_W-1:0] dest_q, dest_d;

    sram_ctrl #(
        .DATA_W      (DATA_W),
        .SRAM_DQ_W   (SRAM_DQ_W),
        .SRAM_ADDR_W (SRAM_ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES),
        .BASE_ADDR   (BASE_ADDR)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en_in (mem_r_en_in),
        .mem_w_en_in (mem_w_en_in),
        .addr_in     (alu_result_in),
        .wdata_in    (st_val_in),
        .mem_stall   (stall),
        .rdata       (rdata),
        .sram_dq     (sram_dq),
        .sram_addr   (sram_addr),
        .sram_we_n   (sram_we_n)
    );

    // A store wins when both request bits are set, so only pure loads update.
    assign is_load = mem_r_en_in & ~mem_w_en_in;

    always_comb begin
        pc_d       = pc_q;
        wb_en_d    = 1'b0;
        mem_r_en_d = mem_r_en_q;
        alu_d      = alu_q;
        mrv_d      = mrv_q;
        dest_d     = dest_q;
        if (!stall) begin
            pc_d       = pc_in;
            wb_en_d    = wb_en_in;
            mem_r_en_d = mem_r_en_in;
            alu_d      = alu_result_in;
            dest_d     = dest_in;
            if (is_load) mrv_d = rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_q      <= '0;
            mrv_q      <= '0;
            dest_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            alu_q      <= alu_d;
            mrv_q      <= mrv_d;
            dest_q     <= dest_d;
        end
    end

    assign pc             = pc_q;
    assign wb_en          = wb_en_q;
    assign mem_r_en       = mem_r_en_q;
    assign alu_result     = alu_q;
    assign mem_read_value = mrv_q;
    assign dest           = dest_q;
    assign mem_stall      = stall;

endmodule

// File: tb/tb_mem_stage_param.sv
// Directed bench for mem_stage_param: default build plus a zero-wait build.
module tb_mem_stage_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_result_in, st_val_in;
    logic [4:0]  dest_in;

    logic [31:0] pc, alu_result, mem_read_value;
    logic        wb_en, mem_r_en, mem_stall, sram_we_n;
    logic [4:0]  dest;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;

    logic [31:0] w0_pc, w0_alu, w0_mrv;
    logic        w0_wb_en, w0_mem_r_en, w0_stall, w0_we_n;
    logic [4:0]  w0_dest;
    logic [17:0] w0_addr;
    wire  [15:0] w0_dq;

    logic [15:0] mem_a [0:1023];
    logic [15:0] mem_b [0:1023];
    bit          rd_oe, drv_en;
    logic [15:0] drv_val;

    int checks = 0;
    int errors = 0;
    int bubble_bad = 0;
    int we_cnt [16];
    logic [17:0] first_addr;
    int st;

    typedef struct {
        logic [31:0] pc;
        logic        wb;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic [31:0] e_pc;
        logic        e_wb;
        logic [31:0] e_alu;
        logic [4:0]  e_dst;
        logic        e_stall;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    mem_stage_param u_dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .pc(pc), .wb_en(wb_en), .mem_r_en(mem_r_en), .alu_result(alu_result),
        .mem_read_value(mem_read_value), .dest(dest), .mem_stall(mem_stall),
        .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n)
    );

    mem_stage_param #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .pc(w0_pc), .wb_en(w0_wb_en), .mem_r_en(w0_mem_r_en), .alu_result(w0_alu),
        .mem_read_value(w0_mrv), .dest(w0_dest), .mem_stall(w0_stall),
        .sram_dq(w0_dq), .sram_addr(w0_addr), .sram_we_n(w0_we_n)
    );

    assign sram_dq = drv_en ? drv_val : (rd_oe ? mem_a[sram_addr[9:0]] : 16'hzzzz);
    assign w0_dq   = rd_oe ? mem_b[w0_addr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_we_n) mem_a[sram_addr[9:0]] <= sram_dq;
        if (!w0_we_n) mem_b[w0_addr[9:0]] <= w0_dq;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nop();
        pc_in = 32'h0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        alu_result_in = 32'h0; st_val_in = 32'h0; dest_in = 5'd0;
    endtask

    task automatic run_mem(input bit sel, input bit r, input bit w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] dst, input logic [31:0] p,
                           input bit wb, output int stalls);
        bit done = 1'b0;
        stalls = 0;
        for (int k = 0; k < 16; k++) we_cnt[k] = 0;
        pc_in = p; wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
        alu_result_in = a; st_val_in = d; dest_in = dst;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!sel && !sram_we_n) we_cnt[sram_addr[3:0]]++;
            if (!sel && c == 0) first_addr = sram_addr;
            if (sel ? w0_stall : mem_stall) begin
                stalls++;
                if (!sel && c > 0 && wb_en) bubble_bad++;
            end else begin
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        chk("mem_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h10, 1'b1, 32'h5,        5'd1,  32'h10, 1'b1, 32'h5,        5'd1,  1'b0};
        vecs[1] = '{32'h14, 1'b1, 32'hFFFFFFFF, 5'd2,  32'h14, 1'b1, 32'hFFFFFFFF, 5'd2,  1'b0};
        vecs[2] = '{32'h18, 1'b0, 32'h12345678, 5'd3,  32'h18, 1'b0, 32'h12345678, 5'd3,  1'b0};
        vecs[3] = '{32'h1C, 1'b1, 32'h80000000, 5'd31, 32'h1C, 1'b1, 32'h80000000, 5'd31, 1'b0};
        vecs[4] = '{32'h20, 1'b1, 32'h00000400, 5'd4,  32'h20, 1'b1, 32'h00000400, 5'd4,  1'b0};
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
        end
        rd_oe = 1'b0; drv_en = 1'b0; drv_val = 16'h0;
        rst = 1'b0;
        nop();
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_wb_en", 32'(wb_en), 32'h0);
        chk("rst_alu", alu_result, 32'h0);
        chk("rst_mrv", mem_read_value, 32'h0);
        chk("rst_dest", 32'(dest), 32'h0);
        chk("rst_we_n", 32'(sram_we_n), 32'h1);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            pc_in = vecs[i].pc; wb_en_in = vecs[i].wb; alu_result_in = vecs[i].alu;
            dest_in = vecs[i].dst; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
            @(negedge clk);
            chk("alu_stall", 32'(mem_stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            chk("alu_pc", pc, vecs[i].e_pc);
            chk("alu_wb_en", 32'(wb_en), 32'(vecs[i].e_wb));
            chk("alu_result", alu_result, vecs[i].e_alu);
            chk("alu_dest", 32'(dest), 32'(vecs[i].e_dst));
            chk("alu_mrv", mem_read_value, 32'h0);
        end

        run_mem(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 5'd7, 32'h100, 1'b0, st);
        chk("st_stall_cycles", st, 4);
        chk("st_we_addr2", we_cnt[2], 2);
        chk("st_we_addr3", we_cnt[3], 2);
        chk("st_mem2", 32'(mem_a[2]), 32'hBEEF);
        chk("st_mem3", 32'(mem_a[3]), 32'hDEAD);
        chk("st_bubble", bubble_bad, 0);
        chk("st_pc", pc, 32'h100);
        chk("st_dest", 32'(dest), 32'd7);
        chk("st_mrv", mem_read_value, 32'h0);

        rd_oe = 1'b1;
        run_mem(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 5'd9, 32'h104, 1'b1, st);
        rd_oe = 1'b0;
        chk("ld_stall_cycles", st, 4);
        chk("ld_mrv", mem_read_value, 32'hDEADBEEF);
        chk("ld_wb_en", 32'(wb_en), 32'h1);
        chk("ld_dest", 32'(dest), 32'd9);
        chk("ld_pc", pc, 32'h104);
        chk("ld_mem_r_en", 32'(mem_r_en), 32'h1);

        run_mem(1'b0, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 5'd3, 32'h108, 1'b1, st);
        chk("both_stall_cycles", st, 4);
        chk("both_mem4", 32'(mem_a[4]), 32'hF00D);
        chk("both_mem5", 32'(mem_a[5]), 32'hCAFE);
        chk("both_mrv_kept", mem_read_value, 32'hDEADBEEF);

        run_mem(1'b0, 1'b0, 1'b1, 32'd525312, 32'h12345678, 5'd0, 32'h10C, 1'b0, st);
        chk("wrap_addr", 32'(first_addr), 32'h0);
        chk("wrap_mem0", 32'(mem_a[0]), 32'h5678);
        chk("wrap_mem1", 32'(mem_a[1]), 32'h1234);

        repeat (4) @(posedge clk);
        #1;
        rd_oe = 1'b1;
        run_mem(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 5'd11, 32'h110, 1'b1, st);
        chk("w0_stall_cycles", st, 2);
        chk("w0_mrv", w0_mrv, 32'hDEADBEEF);
        chk("w0_wb_en", 32'(w0_wb_en), 32'h1);
        chk("w0_dest", 32'(w0_dest), 32'd11);
        repeat (6) @(posedge clk);
        rd_oe = 1'b0;

        @(posedge clk);
        #1;
        pc_in = 32'h120; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
        alu_result_in = 32'd1036; st_val_in = 32'h11112222; dest_in = 5'd5;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_mid_beat1_addr", 32'(sram_addr), 32'd7);
        drv_val = 16'h5A5A;
        drv_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_mid_we_n", 32'(sram_we_n), 32'h1);
        chk("rst_mid_dq_released", 32'(sram_dq), 32'h5A5A);
        chk("rst_mid_addr", 32'(sram_addr), 32'h0);
        chk("rst_mid_pc", pc, 32'h0);
        chk("rst_mid_alu", alu_result, 32'h0);
        chk("rst_mid_mrv", mem_read_value, 32'h0);
        chk("rst_mid_dest", 32'(dest), 32'h0);
        nop();
        drv_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_mem6", 32'(mem_a[6]), 32'h2222);
        chk("rst_mid_no_retry", 32'(mem_a[7]), 32'h0);
        chk("rst_mid_idle_we_n", 32'(sram_we_n), 32'h1);

        rd_oe = 1'b1;
        run_mem(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 5'd12, 32'h124, 1'b1, st);
        rd_oe = 1'b0;
        chk("post_rst_stall_cycles", st, 4);
        chk("post_rst_mrv", mem_read_value, 32'hDEADBEEF);
        chk("post_rst_wb_en", 32'(wb_en), 32'h1);
        chk("post_rst_dest", 32'(dest), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
